// File: rtl/lif_pkg.sv
// Shared constants and helpers for the parametrised LIF network.
// Config addresses sit directly after the N_IN weight slots.
package lif_pkg;

    localparam int THR_DEFAULT_C  = 200;
    localparam int LEAK_DEFAULT_C = 1;
    localparam int LEAK_W         = 3;

    function automatic int addr_thr_l1(input int n_in);
        return n_in;
    endfunction

    function automatic int addr_thr_out(input int n_in);
        return n_in + 1;
    endfunction

    function automatic int addr_leak(input int n_in);
        return n_in + 2;
    endfunction

    function automatic logic [63:0] sat_inc(
        input logic [63:0] v,
        input logic [63:0] max
    );
        return (v >= max) ? max : v + 64'd1;
    endfunction

endpackage

// File: rtl/lif_neuron_param.sv
// Single leaky integrate-and-fire neuron with refractory hold.
// Spike and membrane are both registered; ena=0 freezes state.
module lif_neuron_param
    import lif_pkg::*;
#(
    parameter int W      = 8,
    parameter int REFRAC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [W-1:0]      current,
    input  logic [W-1:0]      thr,
    input  logic [LEAK_W-1:0] leak_shift,
    output logic              spike,
    output logic [W-1:0]      state
);

    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    logic [W-1:0]  v_q, v_d;
    logic [RW-1:0] rc_q, rc_d;
    logic          spk_q, spk_d;
    logic [W:0]    acc;

    // v - (v >> s) never underflows, so only the add needs the extra bit
    always_comb begin
        acc   = {1'b0, v_q} - {1'b0, (v_q >> leak_shift)} + {1'b0, current};
        v_d   = v_q;
        rc_d  = rc_q;
        spk_d = 1'b0;
        if (ena) begin
            if (rc_q != '0) begin
                rc_d = rc_q - RW'(1);
                v_d  = '0;
            end else if (acc >= {1'b0, thr}) begin
                spk_d = 1'b1;
                v_d   = '0;
                rc_d  = RW'(REFRAC);
            end else begin
                v_d = acc[W] ? '1 : acc[W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            rc_q  <= '0;
            spk_q <= 1'b0;
        end else begin
            v_q   <= v_d;
            rc_q  <= rc_d;
            spk_q <= spk_d;
        end
    end

    assign spike = spk_q;
    assign state = v_q;

endmodule

// File: rtl/lif_network_param.sv
// N_IN LIF neurons -> clamped signed weighted sum -> output LIF neuron,
// with runtime config registers and a saturating output-spike counter.
module lif_network_param
    import lif_pkg::*;
#(
    parameter int N_IN         = 8,
    parameter int W            = 8,
    parameter int WGT_W        = 4,
    parameter int REFRAC       = 2,
    parameter int THR_DEFAULT  = THR_DEFAULT_C,
    parameter int LEAK_DEFAULT = LEAK_DEFAULT_C,
    parameter int CNT_W        = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic [N_IN*W-1:0]          current,
    input  logic                       cfg_we,
    input  logic [$clog2(N_IN+3)-1:0]  cfg_addr,
    input  logic [W-1:0]               cfg_data,
    input  logic                       cnt_clr,
    output logic [N_IN-1:0]            l1_spikes,
    output logic                       spike_out,
    output logic [W-1:0]               state_out,
    output logic [CNT_W-1:0]           spike_count
);

    localparam int AW = $clog2(N_IN + 3);
    localparam int SW = W + $clog2(N_IN) + WGT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N_IN-1:0][WGT_W-1:0] wgt_q, wgt_d;
    logic [W-1:0]               thr_l1_q, thr_l1_d;
    logic [W-1:0]               thr_out_q, thr_out_d;
    logic [LEAK_W-1:0]          leak_q, leak_d;
    logic [W-1:0]               sum_q, sum_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic signed [SW-1:0]       s_c;

    always_comb begin
        wgt_d     = wgt_q;
        thr_l1_d  = thr_l1_q;
        thr_out_d = thr_out_q;
        leak_d    = leak_q;
        if (cfg_we) begin
            for (int i = 0; i < N_IN; i++) begin
                if (cfg_addr == AW'(i)) wgt_d[i] = cfg_data[WGT_W-1:0];
            end
            if (cfg_addr == AW'(addr_thr_l1(N_IN)))  thr_l1_d  = cfg_data;
            if (cfg_addr == AW'(addr_thr_out(N_IN))) thr_out_d = cfg_data;
            if (cfg_addr == AW'(addr_leak(N_IN)))    leak_d    = cfg_data[LEAK_W-1:0];
        end
    end

    // Signed sum of fired weights, clamped into the unsigned current range
    always_comb begin
        s_c = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (l1_spikes[i]) begin
                s_c = s_c + {{(SW-WGT_W){wgt_q[i][WGT_W-1]}}, wgt_q[i]};
            end
        end
        sum_d = sum_q;
        if (ena) begin
            if (s_c[SW-1])          sum_d = '0;
            else if (|s_c[SW-2:W])  sum_d = '1;
            else                    sum_d = s_c[W-1:0];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (ena && spike_out) begin
            cnt_d = CNT_W'(sat_inc(64'(cnt_q), 64'(CNT_MAX)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) wgt_q[i] <= WGT_W'(1);
            thr_l1_q  <= W'(THR_DEFAULT);
            thr_out_q <= W'(THR_DEFAULT);
            leak_q    <= LEAK_W'(LEAK_DEFAULT);
            sum_q     <= '0;
            cnt_q     <= '0;
        end else begin
            wgt_q     <= wgt_d;
            thr_l1_q  <= thr_l1_d;
            thr_out_q <= thr_out_d;
            leak_q    <= leak_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
        end
    end

    for (genvar i = 0; i < N_IN; i++) begin : g_l1
        logic [W-1:0] v_unused;
        lif_neuron_param #(.W(W), .REFRAC(REFRAC)) u_neuron (
            .clk        (clk),
            .rst_n      (rst_n),
            .ena        (ena),
            .current    (current[i*W +: W]),
            .thr        (thr_l1_q),
            .leak_shift (leak_q),
            .spike      (l1_spikes[i]),
            .state      (v_unused)
        );
    end

    lif_neuron_param #(.W(W), .REFRAC(REFRAC)) u_out (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .current    (sum_q),
        .thr        (thr_out_q),
        .leak_shift (leak_q),
        .spike      (spike_out),
        .state      (state_out)
    );

    assign spike_count = cnt_q;

endmodule

// File: tb/tb_lif_network_param.sv
// Directed bench for lif_network_param; counter narrowed for saturation.
module tb_lif_network_param;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [63:0] current;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic        cnt_clr;
    logic [7:0]  l1_spikes;
    logic        spike_out;
    logic [7:0]  state_out;
    logic [5:0]  spike_count;

    int nchk = 0;
    int nerr = 0;

    lif_network_param #(.CNT_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .current     (current),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cnt_clr     (cnt_clr),
        .l1_spikes   (l1_spikes),
        .spike_out   (spike_out),
        .state_out   (state_out),
        .spike_count (spike_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int a, input int d);
        cfg_we   = 1'b1;
        cfg_addr = 4'(a);
        cfg_data = 8'(d);
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic do_reset();
        ena     = 1'b0;
        current = '0;
        rst_n   = 1'b0;
        #2;
        rst_n   = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int exp_v [7] = '{100, 150, 175, 188, 194, 197, 199};
        bit found;

        rst_n    = 1'b0;
        ena      = 1'b0;
        current  = '0;
        cfg_we   = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        cnt_clr  = 1'b0;
        #12;
        chk("rst_l1", 32'(l1_spikes), 0);
        chk("rst_spk", 32'(spike_out), 0);
        chk("rst_state", 32'(state_out), 0);
        chk("rst_cnt", 32'(spike_count), 0);
        rst_n = 1'b1;

        // period-3 firing at threshold with REFRAC=2
        tick();
        current[7:0] = 8'd200;
        ena = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk("t1_spk", 32'(l1_spikes), (e == 1 || e == 4 || e == 7) ? 1 : 0);
            chk("t1_v", 32'(dut.g_l1[0].u_neuron.state), 0);
        end

        // leaky integration with a 5-cycle hold in the middle
        do_reset();
        current[7:0] = 8'd100;
        ena = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk("t2_v", 32'(dut.g_l1[0].u_neuron.state), 32'(exp_v[e-1]));
            chk("t2_spk", 32'(l1_spikes), 0);
        end
        ena = 1'b0;
        for (int e = 0; e < 5; e++) begin
            tick();
            chk("t2_hold_v", 32'(dut.g_l1[0].u_neuron.state), 175);
            chk("t2_hold_spk", 32'(l1_spikes), 0);
        end
        ena = 1'b1;
        for (int e = 4; e <= 7; e++) begin
            tick();
            chk("t2_v", 32'(dut.g_l1[0].u_neuron.state), 32'(exp_v[e-1]));
        end
        tick();
        chk("t2_fire", 32'(l1_spikes), 1);
        chk("t2_fire_v", 32'(dut.g_l1[0].u_neuron.state), 0);
        tick();
        chk("t2_refr", 32'(l1_spikes), 0);
        chk("t2_refr_v", 32'(dut.g_l1[0].u_neuron.state), 0);

        // sum -> output neuron -> counter latency
        do_reset();
        cfg(9, 3);
        current = {40'd0, 8'd255, 8'd255, 8'd255};
        ena = 1'b1;
        tick();
        chk("t3_l1", 32'(l1_spikes), 7);
        tick();
        chk("t3_sum", 32'(dut.sum_q), 3);
        chk("t3_spk0", 32'(spike_out), 0);
        tick();
        chk("t3_spk1", 32'(spike_out), 1);
        chk("t3_cnt0", 32'(spike_count), 0);
        tick();
        chk("t3_cnt1", 32'(spike_count), 1);
        chk("t3_spk2", 32'(spike_out), 0);

        // inhibitory weight drives the sum negative, clamped to zero
        do_reset();
        cfg(0, 2);
        cfg(1, 8'h0C);
        cfg(9, 3);
        current = {48'd0, 8'd255, 8'd255};
        ena = 1'b1;
        tick();
        chk("t4_l1", 32'(l1_spikes), 3);
        for (int e = 2; e <= 8; e++) begin
            tick();
            chk("t4_sum", 32'(dut.sum_q), 0);
            chk("t4_state", 32'(state_out), 0);
            chk("t4_spk", 32'(spike_out), 0);
        end

        // counter saturation, then clear against a live spike
        do_reset();
        cfg(9, 1);
        current = '1;
        ena = 1'b1;
        repeat (250) tick();
        chk("t5_sat", 32'(spike_count), 63);
        repeat (10) tick();
        chk("t5_sat_hold", 32'(spike_count), 63);
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            if (spike_out) found = 1'b1;
            else tick();
        end
        chk("t5_find", 32'(found), 1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("t5_clr", 32'(spike_count), 0);

        // async reset mid-burst restores outputs and config
        ena = 1'b0;
        cfg(8, 50);
        ena = 1'b1;
        repeat (4) tick();
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            if (spike_out) found = 1'b1;
            else tick();
        end
        chk("t6_find", 32'(found), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_l1", 32'(l1_spikes), 0);
        chk("t6_spk", 32'(spike_out), 0);
        chk("t6_state", 32'(state_out), 0);
        chk("t6_cnt", 32'(spike_count), 0);
        current = '0;
        current[7:0] = 8'd150;
        #1;
        rst_n = 1'b1;
        tick();
        chk("t6_thr_l1", 32'(l1_spikes), 0);
        chk("t6_v", 32'(dut.g_l1[0].u_neuron.state), 150);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
